// File: rtl/fifo_dds_pkg.sv
// fifo_dds_pkg: shared sizing helpers and constants for the fifo_dds_hs block.
// Holds the clog2-based pointer and level widths and the statistics counter
// width used when FIFO_DDS_HS_STATS_EN is defined.
package fifo_dds_pkg;

  // Width of each statistics field (peak level and stall counter).
  localparam int STAT_W = 16;

  // Bits needed to address DEPTH entries (0 .. DEPTH-1). Never less than 1.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Bits needed to hold an occupancy count of 0 .. DEPTH.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_dds_hs_if.sv
// fifo_dds_hs_if: valid/ready write side (up_*) and read side (down_*) of the
// FIFO. The FIFO uses the slave modport; the producer/consumer uses master.
interface fifo_dds_hs_if #(
  parameter int WIDTH = 8
);
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_data;
  logic             down_valid;
  logic             down_ready;
  logic [WIDTH-1:0] down_data;

  modport master (
    output up_valid, up_data, down_ready,
    input  up_ready, down_valid, down_data
  );

  modport slave (
    input  up_valid, up_data, down_ready,
    output up_ready, down_valid, down_data
  );
endinterface

// File: rtl/fifo_dds_mem.sv
// fifo_dds_mem: DEPTH x WIDTH storage with one synchronous write port and one
// asynchronous (combinational) read port, giving the FIFO its fall-through head.
module fifo_dds_mem
  import fifo_dds_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [ptr_w(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic [ptr_w(DEPTH)-1:0]   rd_addr,
  output logic [WIDTH-1:0]          rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write the addressed entry on the rising edge.
  // NOTE: the array has no reset; validity is tracked by the pointers and
  // level, so clearing storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_dds_hs.sv
// fifo_dds_hs: single-clock fall-through FIFO with valid/ready handshakes,
// synchronous flush, occupancy level and almost_full/almost_empty flags.
// Optional macro FIFO_DDS_HS_STATS_EN adds debug[31:0] =
// {peak level since reset or flush, saturating count of stalled write offers}.
module fifo_dds_hs
  import fifo_dds_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 10,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  fifo_dds_hs_if.slave            bus,
  output logic [lvl_w(DEPTH)-1:0] level,
  output logic                    almost_full,
  output logic                    almost_empty
`ifdef FIFO_DDS_HS_STATS_EN
  ,output logic [31:0]            debug
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = lvl_w(DEPTH);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0] AE_LVL   = LVL_W'(AE_LEVEL);

  // Parameter sanity, checked while elaborating.
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_dds_hs: DEPTH must be >= 2");
  end
  if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
    $error("fifo_dds_hs: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             push, pop;

  // Handshake flags come from the registered level only, so down_ready never
  // reaches up_ready combinationally; a full FIFO refuses a push even when a
  // pop happens in the same cycle.
  assign bus.up_ready   = (level != FULL_LVL);
  assign bus.down_valid = (level != '0);
  assign push           = bus.up_valid & bus.up_ready;
  assign pop            = bus.down_valid & bus.down_ready;
  assign almost_full    = (level >= AF_LVL);
  assign almost_empty   = (level <= AE_LVL);

  // Next pointers and level: flush wins, otherwise advance on each event.
  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    level_nxt  = level;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      level_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr_nxt = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_nxt = level + LVL_W'(1);
        2'b01:   level_nxt = level - LVL_W'(1);
        default: level_nxt = level;
      endcase
    end
  end

  // Pointer and level registers, cleared asynchronously by reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      level  <= level_nxt;
    end
  end

  // A flush suppresses the write so storage is left untouched.
  fifo_dds_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push & ~flush),
    .wr_addr (wr_ptr),
    .wr_data (bus.up_data),
    .rd_addr (rd_ptr),
    .rd_data (bus.down_data)
  );

`ifdef FIFO_DDS_HS_STATS_EN
  logic [STAT_W-1:0] peak_q;
  logic [STAT_W-1:0] stall_q;

  // Peak tracks the post-edge level so it agrees with level on the same
  // cycle; the stall counter saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q  <= '0;
      stall_q <= '0;
    end else begin
      if (flush)
        peak_q <= '0;
      else if (STAT_W'(level_nxt) > peak_q)
        peak_q <= STAT_W'(level_nxt);
      if (bus.up_valid && !bus.up_ready && (stall_q != '1))
        stall_q <= stall_q + STAT_W'(1);
    end
  end

  assign debug = {peak_q, stall_q};
`endif

endmodule

// File: doc/fifo_dds_hs.md
FIFO_DDS_HS -- requirements
Module: fifo_dds_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per entry.
REQ-002 SHALL have parameter DEPTH, default 10: number of entries; any value >= 2, power of two not required.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2: almost_full threshold in entries.
REQ-004 SHALL have parameter AE_LEVEL, default 2: almost_empty threshold in entries.
REQ-005 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port flush, input, 1: synchronous clear of contents.
REQ-008 SHALL have port up_valid, input, 1: the write side offers data.
REQ-009 SHALL have port up_ready, output, 1: the FIFO accepts data.
REQ-010 SHALL have port up_data, input, WIDTH: write data.
REQ-011 SHALL have port down_valid, output, 1: the head entry is available.
REQ-012 SHALL have port down_ready, input, 1: the consumer takes the head entry.
REQ-013 SHALL have port down_data, output, WIDTH: head entry data.
REQ-014 SHALL have port level, output, $clog2(DEPTH+1): current occupancy.
REQ-015 SHALL have port almost_full, output, 1: level >= AF_LEVEL.
REQ-016 SHALL have port almost_empty, output, 1: level <= AE_LEVEL.

Function
REQ-017 SHALL define push = up_valid & up_ready and pop = down_valid & down_ready.
REQ-018 SHALL drive up_ready = (level != DEPTH) from registered state only; there SHALL be no combinational path from down_ready to up_ready.
REQ-019 SHALL drive down_valid = (level != 0); down_data SHALL show the head entry combinationally (fall-through, zero-cycle read latency).
REQ-020 SHALL make written data visible on down_data on the cycle after the push edge.
REQ-021 SHALL advance each pointer by one on its event and wrap from DEPTH-1 to 0.
REQ-022 SHALL change level by +1 on push-only, by -1 on pop-only, and leave it unchanged on simultaneous push and pop.
REQ-023 SHALL support simultaneous push and pop at any non-full, non-empty level; when full, up_ready=0 blocks the push even if a pop occurs that cycle.
REQ-024 SHALL ignore up_valid while full and down_ready while empty, with no state change.
REQ-025 SHALL, on flush=1, set both pointers and level to 0 on that edge; flush SHALL take priority over a same-cycle push or pop, and the data array SHALL be left unchanged.
REQ-026 SHALL derive almost_full and almost_empty combinationally from the registered level.

Reset
REQ-027 SHALL, while rst_n=0, hold pointers and level at 0, so up_ready=1, down_valid=0, level=0, almost_empty=1 and almost_full=0.
REQ-028 SHALL discard any in-flight contents when reset is asserted mid-operation; the data array SHALL not be reset.

Configuration
REQ-029 SHALL, with macro FIFO_DDS_HS_STATS_EN defined, add output port debug[31:0] = {16-bit peak level since reset or flush, 16-bit count of cycles with up_valid & ~up_ready}; the counter SHALL saturate at 16'hFFFF.
REQ-030 SHALL, without FIFO_DDS_HS_STATS_EN defined, have neither the debug port nor its logic.

Structure
REQ-031 SHALL place in package fifo_dds_pkg the pointer-width and level-width helper functions (clog2-based) and the saturating 16-bit counter width constant.
REQ-032 SHALL use one sub-module, fifo_dds_mem: a DEPTH x WIDTH array with a synchronous write port and an asynchronous read port.
REQ-033 SHALL carry elaboration-time assertions: DEPTH >= 2, 0 <= AE_LEVEL < AF_LEVEL <= DEPTH.

Verification (WIDTH=8, DEPTH=10, AF_LEVEL=8, AE_LEVEL=2)
REQ-034 SHALL cover: push 10 values 0x01..0x0A with down_ready=0 -> level=10, up_ready=0, almost_full=1 from level 8; 11th up_valid ignored.
REQ-035 SHALL cover: drain the full FIFO with down_ready=1 -> down_data 0x01..0x0A in order, then down_valid=0, almost_empty=1 at level<=2.
REQ-036 SHALL cover: 25 cycles of continuous push and pop at level 5 -> level stays 5, pointers wrap past 9 to 0, data order preserved.
REQ-037 SHALL cover: flush with push=1 and pop=1 at level 6 -> next cycle level=0, down_valid=0, up_ready=1.
REQ-038 SHALL cover: rst_n pulsed low between clock edges at level 7 -> outputs reach their reset values immediately, without waiting for a clock edge.
REQ-039 SHALL cover: with FIFO_DDS_HS_STATS_EN, fill to 10 and hold up_valid=1 for 3 cycles -> debug=0x000A0003.
